// File: rtl/cl_pkg.sv
// Shared types and helpers for the CameraLink frame-capture block.
package cl_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StArmed,
        StInFrame,
        StDone
    } cl_state_e;

    // Test-pattern byte: (pixel index + line index) modulo 256.
    function automatic logic [7:0] tp_byte(input logic [7:0] pix, input logic [7:0] line);
        return pix + line;
    endfunction

endpackage

// File: rtl/cl_sig_edge.sv
// Input register stage for CameraLink qualifiers/data, with FVAL/LVAL edge detection
// against the previous registered value.
module cl_sig_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fval,
    input  logic       lval,
    input  logic       dval,
    input  logic [7:0] data,
    output logic       fval_r,
    output logic       lval_r,
    output logic       dval_r,
    output logic [7:0] data_r,
    output logic       fval_rise,
    output logic       fval_fall,
    output logic       lval_fall
);

    logic fval_prev;
    logic lval_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fval_r    <= 1'b0;
            lval_r    <= 1'b0;
            dval_r    <= 1'b0;
            data_r    <= 8'h00;
            fval_prev <= 1'b0;
            lval_prev <= 1'b0;
        end else begin
            fval_r    <= fval;
            lval_r    <= lval;
            dval_r    <= dval;
            data_r    <= data;
            fval_prev <= fval_r;
            lval_prev <= lval_r;
        end
    end

    assign fval_rise = fval_r & ~fval_prev;
    assign fval_fall = ~fval_r & fval_prev;
    assign lval_fall = ~lval_r & lval_prev;

endmodule

// File: rtl/cl_frame_capture.sv
// CameraLink frame capture: frame lock, crop to exp_width x exp_height, sticky length errors.
// Optional macro CL_TESTPAT_EN adds test_mode, replacing forwarded bytes with a test pattern.
module cl_frame_capture
    import cl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             rx_clk,
    input  logic             rx_rst_n,
    input  logic             cl_fval,
    input  logic             cl_lval,
    input  logic             cl_dval,
    input  logic [7:0]       cl_data,
    input  logic             capture_en,
    input  logic [CNT_W-1:0] exp_width,
    input  logic [CNT_W-1:0] exp_height,
`ifdef CL_TESTPAT_EN
    input  logic             test_mode,
`endif
    output logic [7:0]       rxdata,
    output logic             rxdataVld,
    output logic             new_frame,
    output logic             frame_done,
    output logic             busy,
    output logic             line_len_err,
    output logic             frame_len_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       fval_r, lval_r, dval_r;
    logic [7:0] data_r;
    logic       fval_rise, fval_fall, lval_fall;

    cl_sig_edge u_sig_edge (
        .clk       (rx_clk),
        .rst_n     (rx_rst_n),
        .fval      (cl_fval),
        .lval      (cl_lval),
        .dval      (cl_dval),
        .data      (cl_data),
        .fval_r    (fval_r),
        .lval_r    (lval_r),
        .dval_r    (dval_r),
        .data_r    (data_r),
        .fval_rise (fval_rise),
        .fval_fall (fval_fall),
        .lval_fall (lval_fall)
    );

    cl_state_e        state_q;
    logic [CNT_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] line_cnt_q;
    logic [CNT_W-1:0] exp_w_q;
    logic [CNT_W-1:0] exp_h_q;

    logic             pix_acc;
    logic             line_end;
    logic             fwd;
    logic [CNT_W-1:0] line_cnt_nxt;
    logic [7:0]       fwd_byte;

    // FVAL dropping while LVAL is still high closes the open line in the same cycle.
    assign pix_acc  = (state_q == StInFrame) && fval_r && lval_r && dval_r;
    assign line_end = (state_q == StInFrame) && (lval_fall || (fval_fall && lval_r));
    assign fwd      = pix_acc && (pix_cnt_q < exp_w_q) && (line_cnt_q < exp_h_q);

    always_comb begin
        line_cnt_nxt = line_cnt_q;
        if (line_end && !(&line_cnt_q)) begin
            line_cnt_nxt = line_cnt_q + CntOne;
        end
    end

`ifdef CL_TESTPAT_EN
    assign fwd_byte = test_mode ? tp_byte(pix_cnt_q[7:0], line_cnt_q[7:0]) : data_r;
`else
    assign fwd_byte = data_r;
`endif

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q       <= StIdle;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            exp_w_q       <= '0;
            exp_h_q       <= '0;
            rxdata        <= 8'h00;
            rxdataVld     <= 1'b0;
            new_frame     <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
            line_len_err  <= 1'b0;
            frame_len_err <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            new_frame  <= 1'b0;
            frame_done <= 1'b0;
            rxdataVld  <= fwd;
            if (fwd) begin
                rxdata <= fwd_byte;
            end
            if (pix_acc && !(&pix_cnt_q)) begin
                pix_cnt_q <= pix_cnt_q + CntOne;
            end
            if (line_end) begin
                if (pix_cnt_q != exp_w_q) begin
                    line_len_err <= 1'b1;
                end
                pix_cnt_q  <= '0;
                line_cnt_q <= line_cnt_nxt;
            end

            unique case (state_q)
                StIdle: begin
                    if (capture_en) state_q <= StSync;
                end
                StSync: begin
                    if (!capture_en)  state_q <= StIdle;
                    else if (!fval_r) state_q <= StArmed;
                end
                StArmed: begin
                    if (!capture_en) begin
                        state_q <= StIdle;
                    end else if (fval_rise) begin
                        state_q       <= StInFrame;
                        new_frame     <= 1'b1;
                        busy          <= 1'b1;
                        pix_cnt_q     <= '0;
                        line_cnt_q    <= '0;
                        exp_w_q       <= exp_width;
                        exp_h_q       <= exp_height;
                        line_len_err  <= 1'b0;
                        frame_len_err <= 1'b0;
                    end
                end
                StInFrame: begin
                    if (fval_fall) begin
                        state_q    <= StDone;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + CntOne;
                        if (line_cnt_nxt != exp_h_q) begin
                            frame_len_err <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= capture_en ? StArmed : StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cl_frame_capture.sv
// Directed/randomized bench for cl_frame_capture with a frame-level reference model.
module tb_cl_frame_capture;

    logic        clk = 1'b0;
    logic        rx_rst_n;
    logic        cl_fval, cl_lval, cl_dval;
    logic [7:0]  cl_data;
    logic        capture_en;
    logic [15:0] exp_width, exp_height;
    logic        test_mode;
    logic [7:0]  rxdata;
    logic        rxdataVld, new_frame, frame_done, busy, line_len_err, frame_len_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    cl_frame_capture dut (
        .rx_clk        (clk),
        .rx_rst_n      (rx_rst_n),
        .cl_fval       (cl_fval),
        .cl_lval       (cl_lval),
        .cl_dval       (cl_dval),
        .cl_data       (cl_data),
        .capture_en    (capture_en),
        .exp_width     (exp_width),
        .exp_height    (exp_height),
`ifdef CL_TESTPAT_EN
        .test_mode     (test_mode),
`endif
        .rxdata        (rxdata),
        .rxdataVld     (rxdataVld),
        .new_frame     (new_frame),
        .frame_done    (frame_done),
        .busy          (busy),
        .line_len_err  (line_len_err),
        .frame_len_err (frame_len_err),
        .frame_cnt     (frame_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: one entry per expected forwarded byte of the current frame.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int  mw, mh, line_idx, m_frames;
    bit  m_cap, m_lerr, m_ferr, m_tp;
    int  nf_cnt, fd_cnt, ord_viol;

    always @(negedge clk) begin
        if (rxdataVld) begin
            got_q.push_back(rxdata);
            if (!busy || new_frame) ord_viol++;
        end
        if (new_frame) begin
            nf_cnt++;
            if (!busy) ord_viol++;
        end
        if (frame_done) begin
            fd_cnt++;
            if (!busy) ord_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit fv, input bit lv, input bit dv, input logic [7:0] d);
        cl_fval = fv;
        cl_lval = lv;
        cl_dval = dv;
        cl_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        nf_cnt   = 0;
        fd_cnt   = 0;
        ord_viol = 0;
    endtask

    task automatic frame_start(input bit cap);
        m_cap = cap;
        if (cap) begin
            mw       = int'(exp_width);
            mh       = int'(exp_height);
            line_idx = 0;
            m_lerr   = 0;
            exp_q.delete();
        end
        repeat (3) cyc(0, 0, 0, 8'h00);
        repeat (2) cyc(1, 0, 0, 8'h00);
    endtask

    task automatic send_line(input int len, input bit gaps, input bit drop_fval);
        int sent = 0;
        bit dv;
        logic [7:0] d;
        while (sent < len) begin
            dv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d  = 8'($urandom);
            cyc(1, 1, dv, d);
            if (dv) begin
                if (m_cap && sent < mw && line_idx < mh)
                    exp_q.push_back(m_tp ? 8'(sent + line_idx) : d);
                sent++;
            end
        end
        if (m_cap) begin
            if (sent != mw) m_lerr = 1;
            line_idx++;
        end
        if (drop_fval) begin
            cyc(0, 1, 0, 8'h00);
        end else begin
            repeat (2) cyc(1, 0, 0, 8'h00);
        end
    endtask

    task automatic frame_end();
        repeat (5) cyc(0, 0, 0, 8'h00);
        if (m_cap) begin
            m_ferr = (line_idx != mh);
            m_frames++;
        end
    endtask

    task automatic send_frame(input int nl, input int len, input bit gaps, input bit drop_last);
        frame_start(1);
        for (int l = 0; l < nl; l++) send_line(len, gaps, drop_last && (l == nl - 1));
        frame_end();
    endtask

    task automatic check_frame(input string tag, input bit cap);
        int nexp = cap ? exp_q.size() : 0;
        check({tag, " nbytes"}, got_q.size(), nexp);
        if (cap) begin
            for (int i = 0; i < nexp && i < got_q.size(); i++)
                check($sformatf("%s byte%0d", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
            check({tag, " line_len_err"}, {31'h0, line_len_err}, {31'h0, m_lerr});
            check({tag, " frame_len_err"}, {31'h0, frame_len_err}, {31'h0, m_ferr});
        end
        check({tag, " new_frame pulses"}, nf_cnt, cap ? 1 : 0);
        check({tag, " frame_done pulses"}, fd_cnt, cap ? 1 : 0);
        check({tag, " frame_cnt"}, {16'h0, frame_cnt}, m_frames);
        check({tag, " ordering"}, ord_viol, 0);
        clear_mon();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " rxdata"}, {24'h0, rxdata}, 0);
        check({tag, " rxdataVld"}, {31'h0, rxdataVld}, 0);
        check({tag, " new_frame"}, {31'h0, new_frame}, 0);
        check({tag, " frame_done"}, {31'h0, frame_done}, 0);
        check({tag, " busy"}, {31'h0, busy}, 0);
        check({tag, " line_len_err"}, {31'h0, line_len_err}, 0);
        check({tag, " frame_len_err"}, {31'h0, frame_len_err}, 0);
        check({tag, " frame_cnt"}, {16'h0, frame_cnt}, 0);
    endtask

    initial begin
        rx_rst_n   = 1'b0;
        cl_fval    = 1'b0;
        cl_lval    = 1'b0;
        cl_dval    = 1'b0;
        cl_data    = 8'h00;
        capture_en = 1'b0;
        exp_width  = 16'd4;
        exp_height = 16'd3;
        test_mode  = 1'b0;
        m_tp       = 0;
        m_frames   = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rx_rst_n   = 1'b1;
        capture_en = 1'b1;
        repeat (3) cyc(0, 0, 0, 8'h00);

        // Clean 4x3 frame
        send_frame(3, 4, 0, 0);
        check_frame("clean4x3", 1);

        // Capture enabled only after FVAL is already high: frame skipped
        capture_en = 1'b0;
        repeat (3) cyc(0, 0, 0, 8'h00);
        frame_start(0);
        capture_en = 1'b1;
        for (int l = 0; l < 3; l++) send_line(4, 0, 0);
        frame_end();
        check_frame("late_enable", 0);
        send_frame(3, 4, 1, 0);
        check_frame("after_late_enable", 1);

        send_frame(3, 6, 1, 0);
        check_frame("long_lines", 1);
        send_frame(3, 3, 1, 0);
        check_frame("short_lines", 1);

        exp_height = 16'd2;
        send_frame(3, 4, 1, 0);
        check_frame("extra_line", 1);
        send_frame(2, 4, 1, 0);
        check_frame("clean_clears", 1);

        // FVAL falls while LVAL is still high on the final line
        exp_height = 16'd3;
        send_frame(3, 4, 1, 1);
        check_frame("fval_drop_lval_high", 1);

        // Size change mid-frame is ignored
        frame_start(1);
        send_line(4, 1, 0);
        exp_width  = 16'd2;
        exp_height = 16'd1;
        send_line(4, 1, 0);
        send_line(4, 1, 0);
        frame_end();
        check_frame("midframe_size_change", 1);

        exp_width  = 16'd0;
        exp_height = 16'd3;
        send_frame(3, 4, 0, 0);
        check_frame("zero_width", 1);
        exp_width = 16'd4;

        // Asynchronous reset mid-line
        frame_start(1);
        send_line(4, 0, 0);
        for (int i = 0; i < 2; i++) cyc(1, 1, 1, 8'($urandom));
        rx_rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        cyc(1, 1, 1, 8'h5a);
        rx_rst_n = 1'b1;
        m_cap    = 0;
        m_frames = 0;
        clear_mon();
        cyc(1, 1, 1, 8'h3c);
        send_line(2, 0, 0);
        send_line(4, 0, 0);
        frame_end();
        check_frame("reset_partial", 0);
        send_frame(3, 4, 1, 0);
        check_frame("after_reset", 1);

`ifdef CL_TESTPAT_EN
        test_mode  = 1'b1;
        m_tp       = 1;
        exp_height = 16'd2;
        send_frame(2, 4, 1, 0);
        check_frame("testpat", 1);
        test_mode = 1'b0;
        m_tp      = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
